// File: rtl/pdm_corr_pkg.sv
// Shared types and default sizes for the PDM correlator lag tracker.
package pdm_corr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      FILL,
      ACCUM,
      DECIDE
   } state_t;

   localparam int DEF_MAX_LAG  = 15;
   localparam int DEF_LAG_W    = 5;
   localparam int DEF_WIN_W    = 8;
   localparam int DEF_LOCK_CNT = 4;
   localparam int LEN_W        = 8;

endpackage

// File: rtl/pdm_vote_accum.sv
// Early/late vote accumulator: signed score over a window of samples.
module pdm_vote_accum
   import pdm_corr_pkg::*;
#(
   parameter int WIN_W = DEF_WIN_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    en,
   input  logic                    pos,
   input  logic                    neg,
   input  logic [WIN_W-1:0]        win_len,
   output logic signed [WIN_W:0]   score,
   output logic                    done
);

   logic [WIN_W-1:0] cnt;
   logic [WIN_W-1:0] last;

   // A zero-length window behaves as a single sample.
   assign last = (win_len == '0) ? '0 : win_len - WIN_W'(1);
   assign done = en && (cnt == last);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt   <= '0;
         score <= '0;
      end else if (en) begin
         cnt <= cnt + WIN_W'(1);
         if (pos && !neg) begin
            score <= score + (WIN_W+1)'(1);
         end else if (neg && !pos) begin
            score <= score - (WIN_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/pdm_lag_tracker.sv
// Closed-loop lag tracker for the PDM correlator.
// Lock detection is built only when PDM_LAG_LOCK_DETECT_EN is defined.
module pdm_lag_tracker
   import pdm_corr_pkg::*;
#(
   parameter int MAX_LAG  = DEF_MAX_LAG,
   parameter int LAG_W    = DEF_LAG_W,
   parameter int WIN_W    = DEF_WIN_W,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_W-1:0]        length,
   input  logic [WIN_W-1:0]        win_len,
   input  logic                    pos,
   input  logic                    neg,
   output logic                    buf_rst,
   output logic signed [LAG_W-1:0] lag,
   output logic                    lag_valid,
   output logic                    locked,
   output logic                    busy
);

   localparam logic signed [LAG_W-1:0] LAG_HI  = LAG_W'(MAX_LAG);
   localparam logic signed [LAG_W-1:0] LAG_LO  = LAG_W'(-MAX_LAG);
   localparam logic signed [LAG_W-1:0] LAG_ONE = LAG_W'(1);

   state_t                  state;
   state_t                  state_n;
   logic [LEN_W-1:0]        len_sh;
   logic [LEN_W-1:0]        fill_cnt;
   logic [WIN_W-1:0]        win_sh;
   logic signed [WIN_W:0]   score;
   logic                    done;
   logic                    acc_en;
   logic                    up;
   logic                    dn;
   logic                    step;
   logic signed [LAG_W-1:0] lag_n;

   assign acc_en = (state == ACCUM);

   pdm_vote_accum #(
      .WIN_W (WIN_W)
   ) u_vote (
      .clk     (clk),
      .rst     (rst),
      .clear   (!acc_en),
      .en      (acc_en),
      .pos     (pos),
      .neg     (neg),
      .win_len (win_sh),
      .score   (score),
      .done    (done)
   );

   assign up    = (state == DECIDE) && !score[WIN_W] && (score != '0)
                  && (lag < LAG_HI);
   assign dn    = (state == DECIDE) && score[WIN_W] && (lag > LAG_LO);
   assign step  = up || dn;
   assign lag_n = up ? lag + LAG_ONE : (dn ? lag - LAG_ONE : lag);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = FLUSH;
         FLUSH:   state_n = FILL;
         FILL:    if (fill_cnt == len_sh) state_n = ACCUM;
         ACCUM:   if (done) state_n = DECIDE;
         DECIDE:  state_n = step ? FLUSH : ACCUM;
         default: state_n = IDLE;
      endcase
      // Dropping start aborts immediately; no decision is taken.
      if (!start) state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_sh    <= '0;
         win_sh    <= '0;
         fill_cnt  <= '0;
         lag       <= '0;
         lag_valid <= 1'b0;
         buf_rst   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         buf_rst   <= (state_n == FLUSH);
         busy      <= (state_n != IDLE);
         lag_valid <= (state == DECIDE) && start;
         if (state == FLUSH) begin
            len_sh   <= length;
            win_sh   <= win_len;
            fill_cnt <= '0;
         end else if (state == FILL) begin
            fill_cnt <= fill_cnt + LEN_W'(1);
         end
         if ((state == DECIDE) && start) begin
            lag <= lag_n;
         end
      end
   end

`ifdef PDM_LAG_LOCK_DETECT_EN
   localparam int LK_W = $clog2(LOCK_CNT + 1);

   logic [LK_W-1:0] lock_cnt;

   always_ff @(posedge clk) begin
      if (rst || ((state != IDLE) && !start)) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (state == DECIDE) begin
         if (step) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
         end else begin
            if (lock_cnt != LK_W'(LOCK_CNT)) begin
               lock_cnt <= lock_cnt + LK_W'(1);
            end
            locked <= (lock_cnt >= LK_W'(LOCK_CNT - 1));
         end
      end
   end
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_lag_tracker.sv
// Scoreboard bench for pdm_lag_tracker: decision gaps, lag, flushes, lock.
module tb_pdm_lag_tracker;

`ifdef PDM_LAG_LOCK_DETECT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              pos = 1'b0;
   logic              neg = 1'b0;
   logic [7:0]        length = 8'd16;
   logic [7:0]        win_len = 8'd8;
   logic              buf_rst;
   logic signed [4:0] lag;
   logic              lag_valid;
   logic              locked;
   logic              busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] pn;
      int         pat;
      int         len;
      int         wl;
      int         lg;
      int         gap;
      int         bufs;
      bit         lk;
   } exp_t;

   exp_t sb[$];
   int   m_lag = 0;
   int   m_cnt = 0;

   logic [1:0] pat_a [5] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01};
   logic [1:0] pat_b [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};

   always #5 clk = ~clk;

   pdm_lag_tracker dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .length    (length),
      .win_len   (win_len),
      .pos       (pos),
      .neg       (neg),
      .buf_rst   (buf_rst),
      .lag       (lag),
      .lag_valid (lag_valid),
      .locked    (locked),
      .busy      (busy)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Edges until lag_valid, counting buf_rst samples on the way.
   task automatic wait_valid(output int n, output int nb);
      n = 0;
      nb = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (buf_rst) nb++;
      end while (!lag_valid && n < 300);
   endtask

   // Queue one expected decision; lock expectation comes from a hold counter.
   task automatic push(logic [1:0] pn, int pat, int len, int wl,
                       int lg, int gap, int bufs);
      exp_t e;
      if (lg == m_lag) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      else m_cnt = 0;
      m_lag = lg;
      e.pn = pn;
      e.pat = pat;
      e.len = len;
      e.wl = wl;
      e.lg = lg;
      e.gap = gap;
      e.bufs = bufs;
      e.lk = LOCK_EN && (m_cnt >= 4);
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      pos = 1'b0;
      neg = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      m_lag = 0;
      m_cnt = 0;
   endtask

   task automatic test_reset();
      exp_t e;
      int n, nb;
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({buf_rst, lag_valid, locked, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL rst_flags got=%b exp=0000",
                  {buf_rst, lag_valid, locked, busy});
      end
      checks++;
      if (lag !== 5'sd0) begin
         failures++;
         $display("FAIL rst_lag got=%0d exp=0", lag);
      end
      rst = 1'b0;
      m_lag = 0;
      m_cnt = 0;
      start = 1'b1;
      push(2'b00, 0, 16, 8, 0, 28, 1);
      repeat (3) push(2'b00, 0, 16, 8, 0, 9, 0);
      push(2'b10, 0, 16, 8, 1, 9, 1);
      push(2'b00, 0, 16, 8, 1, 27, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {pos, neg} = e.pn;
         length = 8'(e.len);
         win_len = 8'(e.wl);
         wait_valid(n, nb);
         checks++;
         if (n !== e.gap) begin
            failures++;
            $display("FAIL reset_gap got=%0d exp=%0d", n, e.gap);
         end
         checks++;
         if (int'(lag) !== e.lg) begin
            failures++;
            $display("FAIL reset_lag got=%0d exp=%0d", lag, e.lg);
         end
         checks++;
         if (nb !== e.bufs) begin
            failures++;
            $display("FAIL reset_bufrst got=%0d exp=%0d", nb, e.bufs);
         end
         checks++;
         if (locked !== e.lk) begin
            failures++;
            $display("FAIL reset_locked got=%b exp=%b", locked, e.lk);
         end
      end
   endtask

   task automatic test_step_up_down();
      exp_t e;
      int n, nb;
      do_reset();
      start = 1'b1;
      push(2'b10, 0, 4, 4, 1, 12, 2);
      for (int k = 2; k <= 15; k++) push(2'b10, 0, 4, 4, k, 11, 1);
      push(2'b10, 0, 4, 4, 15, 11, 0);
      repeat (3) push(2'b10, 0, 4, 4, 15, 5, 0);
      push(2'b01, 0, 4, 4, 14, 5, 1);
      for (int k = 13; k >= -15; k--) push(2'b01, 0, 4, 4, k, 11, 1);
      push(2'b01, 0, 4, 4, -15, 11, 0);
      repeat (20) push(2'b11, 0, 4, 4, -15, 5, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {pos, neg} = e.pn;
         length = 8'(e.len);
         win_len = 8'(e.wl);
         wait_valid(n, nb);
         checks++;
         if (n !== e.gap) begin
            failures++;
            $display("FAIL step_gap got=%0d exp=%0d lag=%0d", n, e.gap, e.lg);
         end
         checks++;
         if (int'(lag) !== e.lg) begin
            failures++;
            $display("FAIL step_lag got=%0d exp=%0d", lag, e.lg);
         end
         checks++;
         if (nb !== e.bufs) begin
            failures++;
            $display("FAIL step_bufrst got=%0d exp=%0d lag=%0d", nb, e.bufs, e.lg);
         end
         checks++;
         if (locked !== e.lk) begin
            failures++;
            $display("FAIL step_locked got=%b exp=%b", locked, e.lk);
         end
      end
   endtask

   task automatic test_majority();
      exp_t e;
      int n, nb, k, kb;
      do_reset();
      start = 1'b1;
      push(2'b00, 0, 4, 5, 0, 13, 1);
      push(2'b00, 1, 4, 5, 1, 6, 1);
      push(2'b00, 0, 4, 5, 1, 12, 0);
      push(2'b00, 2, 4, 5, 1, 6, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         length = 8'(e.len);
         win_len = 8'(e.wl);
         n = 0;
         nb = 0;
         if (e.pat != 0) begin
            for (int i = 0; i < 5; i++) begin
               {pos, neg} = (e.pat == 1) ? pat_a[i] : pat_b[i];
               @(posedge clk);
               #1;
               n++;
               if (buf_rst) nb++;
            end
         end
         {pos, neg} = e.pn;
         wait_valid(k, kb);
         n += k;
         nb += kb;
         checks++;
         if (n !== e.gap) begin
            failures++;
            $display("FAIL vote_gap got=%0d exp=%0d", n, e.gap);
         end
         checks++;
         if (int'(lag) !== e.lg) begin
            failures++;
            $display("FAIL vote_lag got=%0d exp=%0d pat=%0d", lag, e.lg, e.pat);
         end
         checks++;
         if (nb !== e.bufs) begin
            failures++;
            $display("FAIL vote_bufrst got=%0d exp=%0d", nb, e.bufs);
         end
         checks++;
         if (locked !== e.lk) begin
            failures++;
            $display("FAIL vote_locked got=%b exp=%b", locked, e.lk);
         end
      end
   endtask

   task automatic test_abort_shadow();
      exp_t e;
      int n, nb, nv;
      start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_accum_busy got=%b exp=0", busy);
      end
      length = 8'd4;
      win_len = 8'd4;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL fill_busy got=%b exp=1", busy);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_fill_busy got=%b exp=0", busy);
      end
      checks++;
      if (lag !== 5'sd1) begin
         failures++;
         $display("FAIL abort_lag got=%0d exp=1", lag);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL abort_locked got=%b exp=0", locked);
      end
      nv = lag_valid ? 1 : 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (lag_valid) nv++;
      end
      checks++;
      if (nv !== 0) begin
         failures++;
         $display("FAIL abort_valid got=%0d exp=0", nv);
      end
      m_cnt = 0;
      start = 1'b1;
      push(2'b00, 0, 4, 4, 1, 12, 1);
      push(2'b00, 0, 10, 2, 1, 5, 0);
      push(2'b10, 0, 10, 2, 2, 5, 1);
      push(2'b00, 0, 10, 2, 2, 15, 0);
      push(2'b00, 0, 10, 2, 2, 3, 0);
      push(2'b10, 0, 0, 0, 3, 3, 1);
      push(2'b00, 0, 0, 0, 3, 4, 0);
      push(2'b00, 0, 0, 0, 3, 2, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {pos, neg} = e.pn;
         length = 8'(e.len);
         win_len = 8'(e.wl);
         wait_valid(n, nb);
         checks++;
         if (n !== e.gap) begin
            failures++;
            $display("FAIL shadow_gap got=%0d exp=%0d", n, e.gap);
         end
         checks++;
         if (int'(lag) !== e.lg) begin
            failures++;
            $display("FAIL shadow_lag got=%0d exp=%0d", lag, e.lg);
         end
         checks++;
         if (nb !== e.bufs) begin
            failures++;
            $display("FAIL shadow_bufrst got=%0d exp=%0d", nb, e.bufs);
         end
         checks++;
         if (locked !== e.lk) begin
            failures++;
            $display("FAIL shadow_locked got=%b exp=%b", locked, e.lk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_step_up_down();
      test_majority();
      test_abort_shadow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
